// File: rtl/sm_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions and serializer state encoding.
package sm_uart_tx_pkg;

    typedef enum logic [1:0] {
        RegTxData  = 2'd0,
        RegStatus  = 2'd1,
        RegBaudDiv = 2'd2,
        RegCtrl    = 2'd3
    } reg_addr_e;

    localparam int unsigned StatFullBit  = 0;
    localparam int unsigned StatEmptyBit = 1;
    localparam int unsigned StatBusyBit  = 2;
    localparam int unsigned StatOvfBit   = 3;
    localparam int unsigned StatCountLsb = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sm_uart_tx_if.sv
// CPU data-bus slice seen by the UART: decoder select, address, write strobe and data,
// plus the combinational read-data return path.
interface sm_uart_tx_if;
    logic        b_sel;
    logic [31:0] b_addr;
    logic        b_we;
    logic [31:0] b_wdata;
    logic [31:0] b_rdata;

    modport master (
        output b_sel,
        output b_addr,
        output b_we,
        output b_wdata,
        input  b_rdata
    );

    modport slave (
        input  b_sel,
        input  b_addr,
        input  b_we,
        input  b_wdata,
        output b_rdata
    );
endinterface

// File: rtl/sm_fifo_sync.sv
// Synchronous FIFO with occupancy count; full/empty derive from the count so
// wrapped pointers never alias. Depth must be a power of two.
module sm_fifo_sync #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rptr_q];

    // Full is judged on the pre-pop count, so a push into a full FIFO is dropped
    // even when a pop happens in the same cycle.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sm_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register block, TX FIFO and a serializer
// FSM whose output bit is registered so the line never glitches.
module sm_uart_tx
    import sm_uart_tx_pkg::*;
#(
    parameter int unsigned FifoDepth = 8,
    parameter int unsigned DivWidth  = 16,
    parameter int unsigned DivReset  = 434
) (
    input  logic          clk,
    input  logic          rst,
    sm_uart_tx_if.slave   bus_io,
    output logic          uart_tx_o
);

    localparam int unsigned CntW = $clog2(FifoDepth) + 1;

    reg_addr_e           addr;
    logic                wr_en, push_req, pop;
    logic                fifo_full, fifo_empty;
    logic [CntW-1:0]     fifo_count;
    logic [7:0]          fifo_data;

    logic                ovf_q, ovf_d;
    logic                enable_q, enable_d;
    logic [DivWidth-1:0] baud_div_q, baud_div_d;

    tx_state_e           state_q, state_d;
    logic [DivWidth-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shift_q, shift_d;
    logic                tx_q, tx_d;

    logic                unused_bus;

    assign addr      = reg_addr_e'(bus_io.b_addr[3:2]);
    assign wr_en     = bus_io.b_sel & bus_io.b_we;
    assign push_req  = wr_en && (addr == RegTxData);
    assign uart_tx_o = tx_q;
    assign unused_bus = ^{bus_io.b_addr[31:4], bus_io.b_addr[1:0], bus_io.b_wdata};

    sm_fifo_sync #(
        .Width (8),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_req),
        .data_i  (bus_io.b_wdata[7:0]),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        ovf_d      = ovf_q;
        enable_d   = enable_q;
        baud_div_d = baud_div_q;
        if (wr_en) begin
            case (addr)
                RegStatus:  if (bus_io.b_wdata[StatOvfBit]) ovf_d = 1'b0;
                RegBaudDiv: baud_div_d = bus_io.b_wdata[DivWidth-1:0];
                RegCtrl:    enable_d = bus_io.b_wdata[0];
                default:    ;
            endcase
        end
        if (push_req && fifo_full) ovf_d = 1'b1;
    end

    // tx_d tracks the line level of the state being entered, keeping uart_tx_o a pure flop.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (enable_q && !fifo_empty) begin
                    pop        = 1'b1;
                    shift_d    = fifo_data;
                    baud_cnt_d = baud_div_q;
                    bit_idx_d  = 3'd0;
                    state_d    = StStart;
                    tx_d       = 1'b0;
                end
            end
            StStart: begin
                if (baud_cnt_q == '0) begin
                    baud_cnt_d = baud_div_q;
                    state_d    = StData;
                    tx_d       = shift_q[0];
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            StData: begin
                if (baud_cnt_q == '0) begin
                    shift_d    = shift_q >> 1;
                    baud_cnt_d = baud_div_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            StStop: begin
                tx_d = 1'b1;
                if (baud_cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q      <= 1'b0;
            enable_q   <= 1'b1;
            baud_div_q <= DivWidth'(DivReset);
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            ovf_q      <= ovf_d;
            enable_q   <= enable_d;
            baud_div_q <= baud_div_d;
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        bus_io.b_rdata = '0;
        if (bus_io.b_sel) begin
            case (addr)
                RegStatus: begin
                    bus_io.b_rdata[StatFullBit]          = fifo_full;
                    bus_io.b_rdata[StatEmptyBit]         = fifo_empty;
                    bus_io.b_rdata[StatBusyBit]          = (state_q != StIdle);
                    bus_io.b_rdata[StatOvfBit]           = ovf_q;
                    bus_io.b_rdata[StatCountLsb +: CntW] = fifo_count;
                end
                RegBaudDiv: bus_io.b_rdata[DivWidth-1:0] = baud_div_q;
                RegCtrl:    bus_io.b_rdata[0] = enable_q;
                default:    ;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_uart_tx.sv
// Directed bench for sm_uart_tx: register reset values, frame timing, FIFO
// overflow, mid-frame baud change, enable clear and mid-frame reset.
module tb_sm_uart_tx;

    localparam logic [31:0] AddrTx   = 32'h0;
    localparam logic [31:0] AddrStat = 32'h4;
    localparam logic [31:0] AddrBaud = 32'h8;
    localparam logic [31:0] AddrCtrl = 32'hC;

    logic clk = 1'b0;
    logic rst;
    logic uart_tx;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sm_uart_tx_if bus ();

    sm_uart_tx #(
        .FifoDepth (8),
        .DivWidth  (16),
        .DivReset  (434)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_io    (bus),
        .uart_tx_o (uart_tx)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Expected line level for bit slot n of a frame (0 start, 1..8 data LSB first, 9 stop).
    function automatic logic frame_bit(input logic [7:0] b, input int n);
        if (n == 0) return 1'b0;
        if (n >= 9) return 1'b1;
        return b[n-1];
    endfunction

    // Callers sit in the clock-low phase; the write lands on the next posedge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus.b_sel   = 1'b1;
        bus.b_we    = 1'b1;
        bus.b_addr  = addr;
        bus.b_wdata = data;
        @(negedge clk);
        bus.b_sel = 1'b0;
        bus.b_we  = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus.b_sel  = 1'b1;
        bus.b_we   = 1'b0;
        bus.b_addr = addr;
        #1;
        data = bus.b_rdata;
        bus.b_sel = 1'b0;
    endtask

    task automatic drive_cycle(input logic we, input logic [31:0] addr, input logic [31:0] data);
        bus.b_sel   = 1'b1;
        bus.b_we    = we;
        bus.b_addr  = addr;
        bus.b_wdata = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          busy_cnt;
        int          lows;

        bus.b_sel   = 1'b0;
        bus.b_we    = 1'b0;
        bus.b_addr  = '0;
        bus.b_wdata = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset values and deselected read
        bus.b_addr = AddrBaud;
        #1;
        check_eq("rd_unselected", bus.b_rdata, 32'h0);
        bus_read(AddrTx, rd);   check_eq("rst_txdata", rd, 32'h0);
        bus_read(AddrStat, rd); check_eq("rst_status", rd, 32'h2);
        bus_read(AddrBaud, rd); check_eq("rst_bauddiv", rd, 32'd434);
        bus_read(AddrCtrl, rd); check_eq("rst_ctrl", rd, 32'h1);
        check_eq("rst_tx", {31'b0, uart_tx}, 32'h1);
        @(negedge clk);

        // Single frame 0xA5 at BAUDDIV=3
        bus_write(AddrBaud, 32'd3);
        bus_write(AddrTx, 32'hA5);
        busy_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            drive_cycle(1'b0, AddrStat, 32'h0);
            #1;
            e = (i >= 1 && i <= 40) ? frame_bit(8'hA5, (i - 1) / 4) : 1'b1;
            check_eq("a5_tx", {31'b0, uart_tx}, {31'b0, e});
            busy_cnt += int'(bus.b_rdata[2]);
            @(negedge clk);
        end
        bus.b_sel = 1'b0;
        check_eq("a5_busy_cycles", busy_cnt, 32'd40);

        // Overflow with enable off, then drain eight frames
        bus_write(AddrCtrl, 32'h0);
        for (int b = 0; b < 9; b++) bus_write(AddrTx, b);
        bus_read(AddrStat, rd); check_eq("ovf_status", rd, 32'h809);
        @(negedge clk);
        bus_write(AddrStat, 32'h8);
        bus_read(AddrStat, rd); check_eq("ovf_cleared", rd, 32'h801);
        @(negedge clk);
        bus_write(AddrCtrl, 32'h1);
        for (int i = 0; i < 8 * 41 + 8; i++) begin
            int m, j, r;
            #1;
            m = i - 1;
            j = m / 41;
            r = m % 41;
            if (i == 0 || j >= 8 || r == 40) e = 1'b1;
            else e = frame_bit(j[7:0], r / 4);
            check_eq("burst_tx", {31'b0, uart_tx}, {31'b0, e});
            @(negedge clk);
        end
        bus_read(AddrStat, rd); check_eq("burst_done_status", rd, 32'h2);
        @(negedge clk);

        // BAUDDIV changed to 1 during data bit 2 of 0xFF
        bus_write(AddrTx, 32'hFF);
        for (int i = 0; i < 34; i++) begin
            if (i == 14) drive_cycle(1'b1, AddrBaud, 32'd1);
            else drive_cycle(1'b0, AddrStat, 32'h0);
            #1;
            e = (i >= 1 && i <= 4) ? 1'b0 : 1'b1;
            check_eq("baudchg_tx", {31'b0, uart_tx}, {31'b0, e});
            if (i != 14) begin
                e = (i >= 1 && i <= 28);
                check_eq("baudchg_busy", {31'b0, bus.b_rdata[2]}, {31'b0, e});
            end
            @(negedge clk);
        end
        bus.b_sel = 1'b0;
        bus.b_we  = 1'b0;

        // Enable cleared during data bit 4 with a second byte queued
        bus_write(AddrBaud, 32'd3);
        bus_write(AddrTx, 32'h11);
        bus_write(AddrTx, 32'h22);
        for (int i = 0; i < 50; i++) begin
            if (i == 21) drive_cycle(1'b1, AddrCtrl, 32'h0);
            else drive_cycle(1'b0, AddrStat, 32'h0);
            #1;
            e = (i < 40) ? frame_bit(8'h11, i / 4) : 1'b1;
            check_eq("endis_tx", {31'b0, uart_tx}, {31'b0, e});
            if (i != 21) begin
                e = (i < 40);
                check_eq("endis_busy", {31'b0, bus.b_rdata[2]}, {31'b0, e});
            end
            @(negedge clk);
        end
        bus.b_sel = 1'b0;
        bus.b_we  = 1'b0;
        bus_read(AddrStat, rd); check_eq("endis_status", rd, 32'h100);
        @(negedge clk);

        // Reset during DATA of 0x22 with 0x33 still queued
        bus_write(AddrTx, 32'h33);
        bus_write(AddrCtrl, 32'h1);
        for (int i = 0; i < 10; i++) begin
            #1;
            e = (i >= 1) ? frame_bit(8'h22, (i - 1) / 4) : 1'b1;
            check_eq("rstmid_tx", {31'b0, uart_tx}, {31'b0, e});
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rstmid_tx_high", {31'b0, uart_tx}, 32'h1);
        bus_read(AddrStat, rd); check_eq("rstmid_status", rd, 32'h2);
        bus_read(AddrBaud, rd); check_eq("rstmid_bauddiv", rd, 32'd434);
        bus_read(AddrCtrl, rd); check_eq("rstmid_ctrl", rd, 32'h1);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            lows += int'(!uart_tx);
        end
        check_eq("rstmid_quiet", lows, 32'd0);
        bus_read(AddrStat, rd); check_eq("rstmid_status_end", rd, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sm_uart_tx.md
Name: sm_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data bus (bAddr/bWe/bWData/bRData), selected by the bus address decoder.
- CPU software writes bytes into a TX FIFO. A serializer drains the FIFO onto a single 8N1 serial line (LSB first, idle high).
- Provides status and baud-divider registers readable in the same cycle, matching the CPU's single-cycle load path.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, >= 2.
- DIV_WIDTH, 16, width of the baud divider register.
- DIV_RESET, 434, reset value of BAUDDIV (50 MHz / 115200).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- bSel  input  1  block selected by address decoder this cycle.
- bAddr  input  32  byte address; only bAddr[3:2] decoded.
- bWe  input  1  write strobe; effective only when bSel=1.
- bWData  input  32  write data.
- bRData  output  32  read data; combinational from bAddr/state; 0 when bSel=0.
- uartTx  output  1  serial output line.

Behaviour:
- Register map (bAddr[3:2]):
  - 0 TXDATA: write pushes bWData[7:0]; reads return 0.
  - 1 STATUS: read-only except bit3.
    - bit0 full; bit1 empty; bit2 busy (FSM != IDLE); bit3 overflow (sticky).
    - bits[8+$clog2(FIFO_DEPTH):8] FIFO count; all other bits 0.
    - Writing 1 to bit3 clears overflow; other bits are ignored.
  - 2 BAUDDIV: r/w, bits[DIV_WIDTH-1:0]. Bit period = BAUDDIV+1 cycles.
  - 3 CTRL: r/w, bit0 enable.
- Reset (synchronous, rst=1 at posedge):
  - uartTx=1, FSM=IDLE, FIFO empty (count 0), overflow=0, BAUDDIV=DIV_RESET, enable=1.
  - bRData follows the reset register values combinationally.
- Push:
  - A TXDATA write with FIFO not full stores the byte at the posedge; count increments.
  - A TXDATA write with FIFO full is dropped and sets overflow. Full is evaluated before any same-cycle pop, so the write is dropped even if a pop occurs that cycle.
  - Simultaneous push (not full) and pop: count unchanged.
- FSM states: IDLE, START, DATA, STOP; bit counter 0..7; down-counter baudCnt.
  - IDLE: uartTx=1.
    - If enable=1 and FIFO not empty: pop the head into the shift register, load baudCnt=BAUDDIV, bitIdx=0, go to START.
  - START: uartTx=0.
    - When baudCnt==0: reload baudCnt, go to DATA; otherwise decrement.
  - DATA: uartTx=shift[0].
    - When baudCnt==0: shift right, reload baudCnt.
    - If bitIdx==7, go to STOP; else bitIdx++.
  - STOP: uartTx=1.
    - When baudCnt==0, go to IDLE.
- Timing:
  - Latency from the accepting TXDATA write posedge (idle, empty FIFO) to the first uartTx=0: 1 cycle; the pop occurs on the next posedge.
  - Each bit lasts BAUDDIV+1 cycles. A frame is 10*(BAUDDIV+1) cycles.
  - Back-to-back frames are separated by exactly 1 IDLE cycle (uartTx=1).
  - uartTx is driven directly from a register (no combinational glitch).
- BAUDDIV written mid-frame: takes effect at the next bit boundary (next reload); the current bit is unaffected. BAUDDIV=0 gives 1-cycle bits.
- Enable cleared mid-frame: the current frame completes; no further pops until enable=1. Pushes are still accepted.
- Reset mid-frame: frame aborted, uartTx=1 the cycle after the reset edge, FIFO contents discarded.
- FIFO pointers wrap modulo FIFO_DEPTH; full/empty come from the count, not from pointer equality alone.

Decomposition:
- Shared header sm_uart.vh:
  - register offsets (UART_TXDATA=2'd0, UART_STATUS=2'd1, UART_BAUDDIV=2'd2, UART_CTRL=2'd3);
  - STATUS bit indices;
  - FSM state encodings (2-bit).
- One sub-module, sm_fifo_sync:
  - parameterized WIDTH/DEPTH synchronous FIFO;
  - push/pop/full/empty/count ports;
  - same clk/rst convention.
- The register block and serializer FSM stay in sm_uart_tx.

Test Plan:
- Reset, then read all registers -> STATUS=0x0000_0002 (empty), BAUDDIV=434, CTRL=1, TXDATA reads 0, uartTx=1.
- BAUDDIV=3, write 0xA5 -> uartTx low 1 cycle after the write. Bits sampled every 4 cycles: 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop). Busy=1 for 40 cycles.
- enable=0, write 9 bytes 0x00..0x08 -> count=8, full=1, overflow=1, byte 0x08 absent. Write STATUS=0x8 -> overflow=0. Set enable=1 -> bytes 0x00..0x07 transmitted with a 1-cycle idle gap between frames.
- BAUDDIV=3, start 0xFF, write BAUDDIV=1 during the data bit 2 period -> bit 2 lasts 4 cycles; bits 3..7 and stop last 2 cycles each.
- Clear enable during data bit 4 of a frame with 2 bytes queued -> frame completes, uartTx stays 1, count=1, busy=0.
- Assert rst during the DATA state -> next cycle uartTx=1, STATUS=0x2, BAUDDIV=434. No further serial activity.
